// File: rtl/sweep_max_tracker_if.sv
// Signal bundle between the tracker FSM / ADC front end (master) and the
// sweep step sequencer with peak search (slave).
interface sweep_max_tracker_if #(
  parameter int ADC_W = 12,
  parameter int POS_W = 8
);
  logic             HS;
  logic             VS;
  logic             MC;
  logic             CNT_RST;
  logic [ADC_W-1:0] ADC_DATA;
  logic             ADC_VALID;
  logic             CNT_L;
  logic             CNT_D;
  logic             CNT_RU;
  logic             STEP_PULSE;
  logic [ADC_W-1:0] MAX_VAL;
  logic [POS_W-1:0] MAX_POS;
  logic             AXIS_V;

  modport master (
    output HS, VS, MC, CNT_RST, ADC_DATA, ADC_VALID,
    input  CNT_L, CNT_D, CNT_RU, STEP_PULSE, MAX_VAL, MAX_POS, AXIS_V
  );

  modport slave (
    input  HS, VS, MC, CNT_RST, ADC_DATA, ADC_VALID,
    output CNT_L, CNT_D, CNT_RU, STEP_PULSE, MAX_VAL, MAX_POS, AXIS_V
  );
endinterface

// File: rtl/sweep_max_tracker.sv
// Servo step pacing and peak search for the horizontal/vertical sweeps, plus
// the return-to-peak step count and the status lines polled by the FSM.
module sweep_max_tracker #(
  parameter int STEPS_H  = 180,
  parameter int STEPS_V  = 90,
  parameter int STEP_DIV = 100000,
  parameter int ADC_W    = 12,
  parameter int POS_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  sweep_max_tracker_if.slave bus
);

  localparam int               DIV_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] STEPS_H_P = POS_W'(STEPS_H);
  localparam logic [POS_W-1:0] STEPS_V_P = POS_W'(STEPS_V);

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_H    = 2'd1,
    PH_V    = 2'd2,
    PH_RET  = 2'd3
  } phase_e;

  logic [DIV_W-1:0] div_r,     div_nxt_s;
  logic [ADC_W-1:0] sample_r,  sample_nxt_s;
  logic [POS_W-1:0] h_cnt_r,   h_cnt_nxt_s;
  logic [POS_W-1:0] v_cnt_r,   v_cnt_nxt_s;
  logic [POS_W-1:0] ret_rem_r, ret_rem_nxt_s;
  logic [ADC_W-1:0] max_val_r, max_val_nxt_s;
  logic [POS_W-1:0] max_pos_r, max_pos_nxt_s;
  logic             axis_v_r,  axis_v_nxt_s;
  logic             step_pulse_r, step_pulse_nxt_s;

  phase_e           phase_s;
  logic             active_s;
  logic             tick_s;
  logic             cnt_l_s;
  logic             cnt_d_s;
  logic             cnt_ru_s;
  logic [POS_W-1:0] sweep_cnt_s;
  logic [POS_W-1:0] sweep_steps_s;
  logic             sweep_open_s;
  logic [POS_W-1:0] cnt_inc_s;
  logic [ADC_W-1:0] base_val_s;
  logic [POS_W-1:0] base_pos_s;
  logic [ADC_W-1:0] upd_val_s;
  logic [POS_W-1:0] upd_pos_s;
  logic             step_s;

  assign cnt_l_s  = (h_cnt_r < STEPS_H_P);
  assign cnt_d_s  = (v_cnt_r < STEPS_V_P);
  assign cnt_ru_s = (ret_rem_r != {POS_W{1'b0}});

  assign bus.CNT_L      = cnt_l_s;
  assign bus.CNT_D      = cnt_d_s;
  assign bus.CNT_RU     = cnt_ru_s;
  assign bus.STEP_PULSE = step_pulse_r;
  assign bus.MAX_VAL    = max_val_r;
  assign bus.MAX_POS    = max_pos_r;
  assign bus.AXIS_V     = axis_v_r;

  // Phase select: HS outranks VS, which outranks MC.
  always_comb begin
    phase_s = PH_IDLE;
    if (bus.HS) begin
      phase_s = PH_H;
    end else if (bus.VS) begin
      phase_s = PH_V;
    end else if (bus.MC) begin
      phase_s = PH_RET;
    end else begin
      phase_s = PH_IDLE;
    end
  end

  assign active_s = (phase_s != PH_IDLE);
  assign tick_s   = active_s && (div_r == DIV_LAST);

  // Next-state datapath: divider, sample latch, sweep stepping, peak search, return count.
  always_comb begin
    div_nxt_s        = div_r;
    sample_nxt_s     = sample_r;
    h_cnt_nxt_s      = h_cnt_r;
    v_cnt_nxt_s      = v_cnt_r;
    ret_rem_nxt_s    = ret_rem_r;
    max_val_nxt_s    = max_val_r;
    max_pos_nxt_s    = max_pos_r;
    axis_v_nxt_s     = axis_v_r;
    step_pulse_nxt_s = 1'b0;
    sweep_cnt_s      = h_cnt_r;
    sweep_steps_s    = STEPS_H_P;
    sweep_open_s     = cnt_l_s;
    base_val_s       = max_val_r;
    base_pos_s       = max_pos_r;

    if (!active_s) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else begin
      div_nxt_s = div_r + DIV_W'(1);
    end

    if (bus.ADC_VALID) begin
      sample_nxt_s = bus.ADC_DATA;
    end else begin
      sample_nxt_s = sample_r;
    end

    case (phase_s)
      PH_V: begin
        sweep_cnt_s   = v_cnt_r;
        sweep_steps_s = STEPS_V_P;
        sweep_open_s  = cnt_d_s;
        // Entering the vertical axis restarts the peak search from zero.
        if (!axis_v_r) begin
          axis_v_nxt_s = 1'b1;
          base_val_s   = {ADC_W{1'b0}};
          base_pos_s   = {POS_W{1'b0}};
        end else begin
          axis_v_nxt_s = axis_v_r;
        end
      end
      default: begin
        sweep_cnt_s   = h_cnt_r;
        sweep_steps_s = STEPS_H_P;
        sweep_open_s  = cnt_l_s;
      end
    endcase

    max_val_nxt_s = base_val_s;
    max_pos_nxt_s = base_pos_s;
    step_s        = ((phase_s == PH_H) || (phase_s == PH_V)) && tick_s && sweep_open_s;
    cnt_inc_s     = sweep_cnt_s + POS_W'(1);

    // Strict compare so a tie keeps the earlier step index.
    if (sample_r > base_val_s) begin
      upd_val_s = sample_r;
      upd_pos_s = sweep_cnt_s;
    end else begin
      upd_val_s = base_val_s;
      upd_pos_s = base_pos_s;
    end

    if (step_s) begin
      max_val_nxt_s    = upd_val_s;
      max_pos_nxt_s    = upd_pos_s;
      step_pulse_nxt_s = 1'b1;
      if (phase_s == PH_V) begin
        v_cnt_nxt_s = cnt_inc_s;
      end else begin
        h_cnt_nxt_s = cnt_inc_s;
      end
      if (cnt_inc_s == sweep_steps_s) begin
        ret_rem_nxt_s = sweep_steps_s - upd_pos_s;
      end else begin
        ret_rem_nxt_s = ret_rem_r;
      end
    end else if ((phase_s == PH_RET) && tick_s && cnt_ru_s) begin
      ret_rem_nxt_s    = ret_rem_r - POS_W'(1);
      step_pulse_nxt_s = 1'b1;
    end else begin
      step_pulse_nxt_s = 1'b0;
    end
  end

  // State registers with async reset and synchronous counter clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_r        <= {DIV_W{1'b0}};
      sample_r     <= {ADC_W{1'b0}};
      h_cnt_r      <= {POS_W{1'b0}};
      v_cnt_r      <= {POS_W{1'b0}};
      ret_rem_r    <= {POS_W{1'b0}};
      max_val_r    <= {ADC_W{1'b0}};
      max_pos_r    <= {POS_W{1'b0}};
      axis_v_r     <= 1'b0;
      step_pulse_r <= 1'b0;
    end else if (bus.CNT_RST) begin
      div_r        <= {DIV_W{1'b0}};
      sample_r     <= {ADC_W{1'b0}};
      h_cnt_r      <= {POS_W{1'b0}};
      v_cnt_r      <= {POS_W{1'b0}};
      ret_rem_r    <= {POS_W{1'b0}};
      max_val_r    <= {ADC_W{1'b0}};
      max_pos_r    <= {POS_W{1'b0}};
      axis_v_r     <= 1'b0;
      step_pulse_r <= 1'b0;
    end else begin
      div_r        <= div_nxt_s;
      sample_r     <= sample_nxt_s;
      h_cnt_r      <= h_cnt_nxt_s;
      v_cnt_r      <= v_cnt_nxt_s;
      ret_rem_r    <= ret_rem_nxt_s;
      max_val_r    <= max_val_nxt_s;
      max_pos_r    <= max_pos_nxt_s;
      axis_v_r     <= axis_v_nxt_s;
      step_pulse_r <= step_pulse_nxt_s;
    end
  end

endmodule

// File: tb/tb_sweep_max_tracker.sv
// Directed bench for sweep_max_tracker with small sweep sizes and a short
// step divider; expected values are worked out by hand.
module tb_sweep_max_tracker;

  localparam int TB_STEPS_H = 8;
  localparam int TB_STEPS_V = 4;
  localparam int TB_DIV     = 4;
  localparam int TB_ADC_W   = 12;
  localparam int TB_POS_W   = 8;

  typedef int samp_t [8];

  logic CLK;
  logic RST;
  int   err_cnt;
  int   chk_cnt;

  sweep_max_tracker_if #(.ADC_W(TB_ADC_W), .POS_W(TB_POS_W)) bus ();

  sweep_max_tracker #(
    .STEPS_H (TB_STEPS_H),
    .STEPS_V (TB_STEPS_V),
    .STEP_DIV(TB_DIV),
    .ADC_W   (TB_ADC_W),
    .POS_W   (TB_POS_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Runs ncyc cycles with the given enables, strobing one sample per step
  // period, and checks that exactly npulse pulses land at multiples of TB_DIV.
  task automatic run_phase(input logic hs, input logic vs, input logic mc, input samp_t samp,
                           input int ncyc, input int npulse, input string tag);
    int   pulses;
    int   bad;
    logic exp_p;
    pulses = 0;
    bad    = 0;
    bus.HS = hs;
    bus.VS = vs;
    bus.MC = mc;
    for (int c = 0; c < ncyc; c++) begin
      bus.ADC_VALID = ((c % TB_DIV) == 0) && (c < 8 * TB_DIV);
      bus.ADC_DATA  = 12'(samp[(c / TB_DIV) % 8]);
      @(negedge CLK);
      exp_p = (((c + 1) % TB_DIV) == 0) && (((c + 1) / TB_DIV) <= npulse);
      if (bus.STEP_PULSE === 1'b1) pulses++;
      if (bus.STEP_PULSE !== exp_p) bad++;
    end
    bus.ADC_VALID = 1'b0;
    check_val({tag, "_pulses"}, pulses, npulse);
    check_val({tag, "_misplaced"}, bad, 0);
  endtask

  initial begin
    int   found;
    samp_t zeros;
    err_cnt = 0;
    chk_cnt = 0;
    zeros   = '{0, 0, 0, 0, 0, 0, 0, 0};
    RST           = 1'b0;
    bus.HS        = 1'b0;
    bus.VS        = 1'b0;
    bus.MC        = 1'b0;
    bus.CNT_RST   = 1'b0;
    bus.ADC_DATA  = 12'd0;
    bus.ADC_VALID = 1'b0;
    repeat (3) @(negedge CLK);

    // 1. reset state and idle
    check_val("rst_cnt_l", bus.CNT_L, 1);
    check_val("rst_cnt_d", bus.CNT_D, 1);
    check_val("rst_cnt_ru", bus.CNT_RU, 0);
    check_val("rst_pulse", bus.STEP_PULSE, 0);
    check_val("rst_max_val", bus.MAX_VAL, 0);
    check_val("rst_axis", bus.AXIS_V, 0);
    RST = 1'b1;
    run_phase(1'b0, 1'b0, 1'b0, zeros, 50, 0, "idle");
    check_val("idle_cnt_l", bus.CNT_L, 1);
    check_val("idle_max_val", bus.MAX_VAL, 0);

    // 2. horizontal sweep: peak 90 first seen at index 2
    run_phase(1'b1, 1'b0, 1'b0, '{10, 20, 90, 40, 90, 5, 5, 5}, 40, 8, "hsweep");
    bus.HS = 1'b0;
    check_val("h_cnt_l", bus.CNT_L, 0);
    check_val("h_max_val", bus.MAX_VAL, 90);
    check_val("h_max_pos", bus.MAX_POS, 2);
    check_val("h_cnt_ru", bus.CNT_RU, 1);
    check_val("h_axis", bus.AXIS_V, 0);

    // 3. return to horizontal peak: 8 - 2 = 6 steps
    run_phase(1'b0, 1'b0, 1'b1, zeros, 40, 6, "hret");
    bus.MC = 1'b0;
    check_val("hret_cnt_ru", bus.CNT_RU, 0);

    // 4. vertical sweep: peak 7 at index 1, return 4 - 1 = 3 steps
    run_phase(1'b0, 1'b1, 1'b0, '{3, 7, 7, 1, 0, 0, 0, 0}, 24, 4, "vsweep");
    bus.VS = 1'b0;
    check_val("v_max_val", bus.MAX_VAL, 7);
    check_val("v_max_pos", bus.MAX_POS, 1);
    check_val("v_axis", bus.AXIS_V, 1);
    check_val("v_cnt_d", bus.CNT_D, 0);
    check_val("v_cnt_ru", bus.CNT_RU, 1);
    run_phase(1'b0, 1'b0, 1'b1, zeros, 20, 3, "vret");
    bus.MC = 1'b0;
    check_val("vret_cnt_ru", bus.CNT_RU, 0);

    // 5. synchronous clear, partial sweep, clear mid-sweep, async reset mid-sweep
    bus.CNT_RST = 1'b1;
    @(negedge CLK);
    bus.CNT_RST = 1'b0;
    check_val("clr_cnt_l", bus.CNT_L, 1);
    check_val("clr_cnt_d", bus.CNT_D, 1);
    check_val("clr_axis", bus.AXIS_V, 0);
    check_val("clr_max_val", bus.MAX_VAL, 0);
    run_phase(1'b1, 1'b0, 1'b0, '{50, 60, 70, 0, 0, 0, 0, 0}, 12, 3, "hpart");
    check_val("hpart_max_val", bus.MAX_VAL, 70);
    check_val("hpart_max_pos", bus.MAX_POS, 2);
    check_val("hpart_cnt_l", bus.CNT_L, 1);
    bus.CNT_RST = 1'b1;
    @(negedge CLK);
    bus.CNT_RST   = 1'b0;
    check_val("clr2_max_val", bus.MAX_VAL, 0);
    check_val("clr2_max_pos", bus.MAX_POS, 0);
    bus.ADC_VALID = 1'b1;
    bus.ADC_DATA  = 12'd33;
    @(negedge CLK);
    bus.ADC_VALID = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (bus.STEP_PULSE === 1'b1) found = 1;
      else @(negedge CLK);
    end
    check_val("clr2_pulse_seen", found, 1);
    check_val("clr2_max_val_33", bus.MAX_VAL, 33);
    check_val("clr2_max_pos_0", bus.MAX_POS, 0);
    RST = 1'b0;
    #1;
    check_val("arst_pulse", bus.STEP_PULSE, 0);
    check_val("arst_max_val", bus.MAX_VAL, 0);
    check_val("arst_cnt_l", bus.CNT_L, 1);
    check_val("arst_cnt_ru", bus.CNT_RU, 0);
    bus.HS = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // 6. HS and MC together with nothing to return: horizontal stepping wins
    run_phase(1'b1, 1'b0, 1'b1, '{1, 2, 3, 0, 0, 0, 0, 0}, 12, 3, "hsmc");
    bus.HS = 1'b0;
    bus.MC = 1'b0;
    check_val("hsmc_cnt_ru", bus.CNT_RU, 0);
    check_val("hsmc_cnt_l", bus.CNT_L, 1);
    check_val("hsmc_max_val", bus.MAX_VAL, 3);
    check_val("hsmc_max_pos", bus.MAX_POS, 2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
